// File: rtl/loop_stack_pkg.sv
// Shared types for the BeeF loop-bracket engine: op codes from control_unit and FSM states.
package loop_stack_pkg;

  typedef enum logic [1:0] {LS_NOP, LS_PUSH, LS_POP, LS_SCAN} loop_op_t;
  typedef enum logic [1:0] {LS_IDLE, LS_SCAN_ST, LS_FAULT} loop_state_t;

endpackage

// File: rtl/loop_stack_mem.sv
// DEPTH x PC_W register file: one synchronous write port, one combinational read port.
module loop_stack_mem #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [PC_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] mem_q [DEPTH];

  // Contents are not reset; the depth pointer alone decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/loop_stack.sv
// Loop-bracket engine: LIFO of '[' return PCs plus a forward scan to the matching ']'.
module loop_stack
  import loop_stack_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DEPTH  = 16,
  parameter int NEST_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  loop_op_t                   op,
  input  logic [PC_W-1:0]            pc_in,
  input  logic                       instr_open,
  input  logic                       instr_close,
  output logic [PC_W-1:0]            load_out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       scanning,
  output logic                       scan_done,
  output logic                       fault
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  loop_state_t       state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic              scan_done_q, scan_done_d;
  logic              we;
  logic [PC_W-1:0]   rdata;

  assign empty = (depth_q == '0);
  assign full  = (depth_q == DW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    nest_d      = nest_q;
    scan_done_d = 1'b0;
    we          = 1'b0;
    case (state_q)
      LS_IDLE: begin
        case (op)
          LS_PUSH: begin
            if (full) state_d = LS_FAULT;
            else begin
              we      = 1'b1;
              depth_d = depth_q + DW'(1);
            end
          end
          LS_POP: begin
            if (empty) state_d = LS_FAULT;
            else       depth_d = depth_q - DW'(1);
          end
          LS_SCAN: begin
            nest_d  = NEST_W'(1);
            state_d = LS_SCAN_ST;
          end
          default: ;
        endcase
      end
      LS_SCAN_ST: begin
        // Simultaneous open+close cancels out; op is ignored while scanning.
        if (instr_open && !instr_close) begin
          if (&nest_q) state_d = LS_FAULT;
          else         nest_d  = nest_q + NEST_W'(1);
        end else if (instr_close && !instr_open) begin
          nest_d = nest_q - NEST_W'(1);
          if (nest_q == NEST_W'(1)) begin
            scan_done_d = 1'b1;
            state_d     = LS_IDLE;
          end
        end
      end
      LS_FAULT: ;
      default: state_d = LS_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LS_IDLE;
      depth_q     <= '0;
      nest_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      nest_q      <= nest_d;
      scan_done_q <= scan_done_d;
    end
  end

  loop_stack_mem #(.PC_W(PC_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we && !reset),
    .waddr (AW'(depth_q)),
    .wdata (pc_in),
    .raddr (AW'(depth_q - DW'(1))),
    .rdata (rdata)
  );

  assign load_out  = empty ? '0 : rdata;
  assign depth     = depth_q;
  assign scanning  = (state_q == LS_SCAN_ST);
  assign scan_done = scan_done_q;
  assign fault     = (state_q == LS_FAULT);

endmodule

// File: tb/tb_loop_stack.sv
// Directed + random bench for loop_stack against a queue-based behavioural model.
module tb_loop_stack;
  import loop_stack_pkg::*;

  localparam int PC_W   = 8;
  localparam int DEPTH  = 4;
  localparam int NEST_W = 2;
  localparam int DW     = $clog2(DEPTH+1);
  localparam int NEST_MAX = (1 << NEST_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  loop_op_t        op;
  logic [PC_W-1:0] pc_in;
  logic            instr_open, instr_close;
  logic [PC_W-1:0] load_out;
  logic [DW-1:0]   depth;
  logic            empty, full, scanning, scan_done, fault;

  int total = 0;
  int bad   = 0;

  // Model: stack as a queue, mode 0=idle 1=scanning 2=faulted, nesting as plain int.
  logic [PC_W-1:0] stk[$];
  int              mode = 0;
  int              nest = 0;
  bit              sdone = 1'b0;

  loop_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .NEST_W(NEST_W)) dut (
    .clk(clk), .reset(reset), .op(op), .pc_in(pc_in),
    .instr_open(instr_open), .instr_close(instr_close),
    .load_out(load_out), .depth(depth), .empty(empty), .full(full),
    .scanning(scanning), .scan_done(scan_done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input loop_op_t o, input logic [PC_W-1:0] pc,
                              input bit opn, input bit cls);
    sdone = 1'b0;
    if (r) begin
      stk.delete();
      mode = 0;
      nest = 0;
    end else if (mode == 0) begin
      if (o == LS_PUSH) begin
        if (stk.size() < DEPTH) stk.push_back(pc);
        else mode = 2;
      end else if (o == LS_POP) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else mode = 2;
      end else if (o == LS_SCAN) begin
        nest = 1;
        mode = 1;
      end
    end else if (mode == 1) begin
      if (opn && !cls) begin
        if (nest == NEST_MAX) mode = 2;
        else nest++;
      end else if (cls && !opn) begin
        nest--;
        if (nest == 0) begin
          sdone = 1'b1;
          mode  = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [PC_W-1:0] exp_load;
    exp_load = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    check({tag, ".load_out"},  32'(load_out),  32'(exp_load));
    check({tag, ".depth"},     32'(depth),     32'(stk.size()));
    check({tag, ".empty"},     32'(empty),     32'(stk.size() == 0));
    check({tag, ".full"},      32'(full),      32'(stk.size() == DEPTH));
    check({tag, ".scanning"},  32'(scanning),  32'(mode == 1));
    check({tag, ".scan_done"}, 32'(scan_done), 32'(sdone));
    check({tag, ".fault"},     32'(fault),     32'(mode == 2));
  endtask

  // One clock: drive on the falling edge, model on the rising edge, compare 1 time unit later.
  task automatic step(input string tag, input bit r, input loop_op_t o,
                      input logic [PC_W-1:0] pc, input bit opn, input bit cls);
    @(negedge clk);
    reset = r; op = o; pc_in = pc; instr_open = opn; instr_close = cls;
    @(posedge clk);
    model_update(r, o, pc, opn, cls);
    #1;
    check_all(tag);
  endtask

  initial begin
    string prog;
    int    scan_hi;
    reset = 1'b1; op = LS_NOP; pc_in = '0; instr_open = 1'b0; instr_close = 1'b0;
    step("rst", 1, LS_NOP, 0, 0, 0);
    step("rst", 1, LS_NOP, 0, 0, 0);

    // Basic push/pop ordering.
    step("t1.push", 0, LS_PUSH, 8'h10, 0, 0);
    step("t1.push", 0, LS_PUSH, 8'h20, 0, 0);
    step("t1.push", 0, LS_PUSH, 8'h30, 0, 0);
    check("t1.top30", 32'(load_out), 32'h30);
    step("t1.pop", 0, LS_POP, 0, 0, 0);
    step("t1.pop", 0, LS_POP, 0, 0, 0);
    check("t1.top10", 32'(load_out), 32'h10);
    step("t1.pop", 0, LS_POP, 0, 0, 0);
    check("t1.empty0", 32'(load_out), 32'h0);

    // Overflow into FAULT; later ops have no effect.
    for (int i = 1; i <= 5; i++) step("t2.push", 0, LS_PUSH, 8'(8'hA0 + i), 0, 0);
    check("t2.keep4th", 32'(load_out), 32'hA4);
    step("t2.pop", 0, LS_POP, 0, 0, 0);
    check("t2.depth4", 32'(depth), 32'd4);
    step("t2.rst", 1, LS_NOP, 0, 0, 0);

    // Underflow into FAULT, push ignored, reset clears.
    step("t3.pop", 0, LS_POP, 0, 0, 0);
    check("t3.fault", 32'(fault), 32'd1);
    step("t3.push", 0, LS_PUSH, 8'h55, 0, 0);
    step("t3.rst", 1, LS_NOP, 0, 0, 0);
    check("t3.fault0", 32'(fault), 32'd0);

    // Forward scan over "[+[-]>]" with one entry on the stack.
    step("t4.push", 0, LS_PUSH, 8'h42, 0, 0);
    step("t4.scan", 0, LS_SCAN, 0, 0, 0);
    prog = "+[-]>]";
    scan_hi = 0;
    for (int i = 0; i < prog.len(); i++) begin
      if (scanning) scan_hi++;
      step("t4.feed", 0, LS_NOP, 0, prog[i] == "[", prog[i] == "]");
    end
    check("t4.scan_cycles", 32'(scan_hi), 32'd6);
    check("t4.done", 32'(scan_done), 32'd1);
    step("t4.after", 0, LS_NOP, 0, 0, 0);
    check("t4.done_pulse", 32'(scan_done), 32'd0);
    check("t4.stack", 32'(load_out), 32'h42);

    // Open+close cancels; op ignored during scan.
    step("t5.scan", 0, LS_SCAN, 0, 0, 0);
    step("t5.both", 0, LS_NOP, 0, 1, 1);
    step("t5.push", 0, LS_PUSH, 8'h77, 0, 0);
    check("t5.depth1", 32'(depth), 32'd1);
    step("t5.close", 0, LS_POP, 0, 0, 1);
    check("t5.done", 32'(scan_done), 32'd1);

    // Reset mid-scan at nest 2, then normal push.
    step("t6.scan", 0, LS_SCAN, 0, 0, 0);
    step("t6.open", 0, LS_NOP, 0, 1, 0);
    step("t6.rst", 1, LS_NOP, 0, 0, 1);
    step("t6.push", 0, LS_PUSH, 8'h99, 0, 0);
    check("t6.top", 32'(load_out), 32'h99);

    // Nest counter saturates into FAULT rather than wrapping.
    step("t7.scan", 0, LS_SCAN, 0, 0, 0);
    for (int i = 0; i < NEST_MAX; i++) step("t7.open", 0, LS_NOP, 0, 1, 0);
    check("t7.fault", 32'(fault), 32'd1);
    step("t7.rst", 1, LS_NOP, 0, 0, 0);

    // Random mix, occasional resets, quicker recovery from FAULT.
    for (int n = 0; n < 600; n++) begin
      bit r;
      loop_op_t o;
      r = ($urandom_range(0, 59) == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
      o = loop_op_t'($urandom_range(0, 3));
      if (o == LS_SCAN && $urandom_range(0, 1) == 0) o = LS_PUSH;
      step("rnd", r, o, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
